uart_rx_ctrl: RTL and testbench

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_rx_ctrl_if.sv | 45 ++++
 rtl/uart_rx_ctrl.sv | 147 ++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_ctrl_if.sv
// Signal bundle between a UART receiver/consumer and uart_rx_ctrl.
// master = receiver + consumer side, slave = the controller.
interface uart_rx_ctrl_if #(
  parameter int unsigned DW = 8
);
  logic          cfg_wr;
  logic [5:0]    cfg_prescale_in;
  logic          cfg_par_en_in;
  logic          cfg_par_typ_in;
  logic          rx_busy;
  logic          rx_frame_done;
  logic [DW-1:0] rx_data;
  logic          rx_par_err;
  logic          rx_stp_err;
  logic          rd_en;
  logic          ovr_clr;
  logic          err_clr;
  logic [5:0]    Prescale;
  logic          Par_En;
  logic          Par_Typ;
  logic          rx_hold;
  logic          cfg_pending;
  logic [DW-1:0] rd_data;
  logic [1:0]    rd_err;
  logic          empty;
  logic          full;
  logic          overrun;
  logic [7:0]    err_cnt;

  modport master (
    output cfg_wr, cfg_prescale_in, cfg_par_en_in, cfg_par_typ_in,
    output rx_busy, rx_frame_done, rx_data, rx_par_err, rx_stp_err,
    output rd_en, ovr_clr, err_clr,
    input  Prescale, Par_En, Par_Typ, rx_hold, cfg_pending,
    input  rd_data, rd_err, empty, full, overrun, err_cnt
  );

  modport slave (
    input  cfg_wr, cfg_prescale_in, cfg_par_en_in, cfg_par_typ_in,
    input  rx_busy, rx_frame_done, rx_data, rx_par_err, rx_stp_err,
    input  rd_en, ovr_clr, err_clr,
    output Prescale, Par_En, Par_Typ, rx_hold, cfg_pending,
    output rd_data, rd_err, empty, full, overrun, err_cnt
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: safe frame-boundary reconfiguration of the receiver
// plus a show-ahead receive FIFO with overrun flag and saturating error counter.
module uart_rx_ctrl #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 8
) (
  input logic          clk,
  input logic          rst,
  uart_rx_ctrl_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned PW = 6;
  localparam int unsigned EW = 8;

  typedef enum logic [1:0] {RUN, WAIT_IDLE, APPLY} state_e;

  typedef struct packed {
    logic          par_err;
    logic          stp_err;
    logic [DW-1:0] data;
  } entry_t;

  state_e        state_q, state_d;
  logic [PW-1:0] sh_pre_q, sh_pre_d, pre_q, pre_d;
  logic          sh_pen_q, sh_pen_d, pen_q, pen_d;
  logic          sh_pty_q, sh_pty_d, pty_q, pty_d;
  logic          hold_q, hold_d;
  logic          pend_q, pend_d;

  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovr_q, ovr_d;
  logic [EW-1:0] ecnt_q, ecnt_d;

  logic          empty, full, push, pop, drop, err_inc;

  // Config FSM: shadow capture on every cfg_wr, apply only once the receiver is idle
  always_comb begin
    state_d  = state_q;
    sh_pre_d = sh_pre_q;
    sh_pen_d = sh_pen_q;
    sh_pty_d = sh_pty_q;
    pre_d    = pre_q;
    pen_d    = pen_q;
    pty_d    = pty_q;
    if (bus.cfg_wr) begin
      sh_pre_d = bus.cfg_prescale_in;
      sh_pen_d = bus.cfg_par_en_in;
      sh_pty_d = bus.cfg_par_typ_in;
    end
    unique case (state_q)
      RUN:       if (bus.cfg_wr) state_d = WAIT_IDLE;
      WAIT_IDLE: if (!bus.rx_busy) state_d = APPLY;
      APPLY: begin
        pre_d   = sh_pre_q;
        pen_d   = sh_pen_q;
        pty_d   = sh_pty_q;
        state_d = bus.cfg_wr ? WAIT_IDLE : RUN;
      end
      default:   state_d = RUN;
    endcase
    hold_d = (state_d != RUN);
    pend_d = (state_d != RUN);
  end

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign pop     = bus.rd_en && !empty;
  assign push    = bus.rx_frame_done && (!full || pop);
  assign drop    = bus.rx_frame_done && full && !pop;
  assign err_inc = bus.rx_frame_done && (bus.rx_par_err || bus.rx_stp_err);

  // FIFO, overrun and error counter; a full FIFO with a same-cycle pop still accepts the push
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovr_d    = ovr_q;
    ecnt_d   = ecnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{par_err: bus.rx_par_err, stp_err: bus.rx_stp_err, data: bus.rx_data};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    if (drop)             ovr_d = 1'b1;
    else if (bus.ovr_clr) ovr_d = 1'b0;
    if (bus.err_clr)                      ecnt_d = err_inc ? EW'(1) : '0;
    else if (err_inc && ecnt_q != '1)     ecnt_d = ecnt_q + EW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      sh_pre_q <= PW'(8);
      sh_pen_q <= 1'b0;
      sh_pty_q <= 1'b0;
      pre_q    <= PW'(8);
      pen_q    <= 1'b0;
      pty_q    <= 1'b0;
      hold_q   <= 1'b0;
      pend_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovr_q    <= 1'b0;
      ecnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      sh_pre_q <= sh_pre_d;
      sh_pen_q <= sh_pen_d;
      sh_pty_q <= sh_pty_d;
      pre_q    <= pre_d;
      pen_q    <= pen_d;
      pty_q    <= pty_d;
      hold_q   <= hold_d;
      pend_q   <= pend_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovr_q    <= ovr_d;
      ecnt_q   <= ecnt_d;
    end
  end

  // Storage needs no reset: contents are only observed through count_q
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.Prescale    = pre_q;
  assign bus.Par_En      = pen_q;
  assign bus.Par_Typ     = pty_q;
  assign bus.rx_hold     = hold_q;
  assign bus.cfg_pending = pend_q;
  assign bus.rd_data     = mem_q[rd_ptr_q].data;
  assign bus.rd_err      = {mem_q[rd_ptr_q].par_err, mem_q[rd_ptr_q].stp_err};
  assign bus.empty       = empty;
  assign bus.full        = full;
  assign bus.overrun     = ovr_q;
  assign bus.err_cnt     = ecnt_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: vector table for config/FIFO behaviour,
// hand-written sequences for mid-frame config, error saturation and reset.
module tb_uart_rx_ctrl;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  uart_rx_ctrl_if #(.DW(8)) bus ();

  uart_rx_ctrl #(.DEPTH(4), .DW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       cw;
    logic [5:0] pre;
    logic       pen, pty, busy, fd;
    logic [7:0] data;
    logic [1:0] err;
    logic       rd, oclr, eclr;
    logic [5:0] e_pre;
    logic       e_pen, e_pty, e_hold, e_pend, e_empty, e_full, e_ovr;
    logic [7:0] e_ecnt, e_hd;
    logic [1:0] e_he;
  } vec_t;

  vec_t vecs [30];

  function automatic vec_t mk(
    input logic cw, input logic [5:0] pre, input logic pen, input logic pty,
    input logic busy, input logic fd, input logic [7:0] data, input logic [1:0] err,
    input logic rd, input logic oclr, input logic eclr,
    input logic [5:0] e_pre, input logic e_pen, input logic e_pty,
    input logic e_hold, input logic e_pend, input logic e_empty, input logic e_full,
    input logic e_ovr, input logic [7:0] e_ecnt, input logic [7:0] e_hd, input logic [1:0] e_he);
    vec_t v;
    v.cw = cw; v.pre = pre; v.pen = pen; v.pty = pty; v.busy = busy; v.fd = fd;
    v.data = data; v.err = err; v.rd = rd; v.oclr = oclr; v.eclr = eclr;
    v.e_pre = e_pre; v.e_pen = e_pen; v.e_pty = e_pty; v.e_hold = e_hold;
    v.e_pend = e_pend; v.e_empty = e_empty; v.e_full = e_full; v.e_ovr = e_ovr;
    v.e_ecnt = e_ecnt; v.e_hd = e_hd; v.e_he = e_he;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.cfg_wr = 0; bus.cfg_prescale_in = 0; bus.cfg_par_en_in = 0; bus.cfg_par_typ_in = 0;
    bus.rx_busy = 0; bus.rx_frame_done = 0; bus.rx_data = 0; bus.rx_par_err = 0;
    bus.rx_stp_err = 0; bus.rd_en = 0; bus.ovr_clr = 0; bus.err_clr = 0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".Prescale"}, int'(bus.Prescale), 8);
    chk({tag, ".Par_En"}, int'(bus.Par_En), 0);
    chk({tag, ".Par_Typ"}, int'(bus.Par_Typ), 0);
    chk({tag, ".rx_hold"}, int'(bus.rx_hold), 0);
    chk({tag, ".cfg_pending"}, int'(bus.cfg_pending), 0);
    chk({tag, ".empty"}, int'(bus.empty), 1);
    chk({tag, ".full"}, int'(bus.full), 0);
    chk({tag, ".overrun"}, int'(bus.overrun), 0);
    chk({tag, ".err_cnt"}, int'(bus.err_cnt), 0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    idle_inputs();

    //        cw pre pen pty bsy fd data  err   rd oc ec | pre pen pty hld pnd emp ful ovr ecnt hd   he
    vecs[0]  = mk(1, 32, 1, 1, 0, 0, 8'h00, 2'b00, 0, 0, 0,   8, 0, 0, 1, 1, 1, 0, 0, 0, 8'h00, 2'b00);
    vecs[1]  = mk(0,  0, 0, 0, 0, 0, 8'h00, 2'b00, 0, 0, 0,   8, 0, 0, 1, 1, 1, 0, 0, 0, 8'h00, 2'b00);
    vecs[2]  = mk(0,  0, 0, 0, 0, 0, 8'h00, 2'b00, 0, 0, 0,  32, 1, 1, 0, 0, 1, 0, 0, 0, 8'h00, 2'b00);
    vecs[3]  = mk(0,  0, 0, 0, 0, 1, 8'h01, 2'b00, 0, 0, 0,  32, 1, 1, 0, 0, 0, 0, 0, 0, 8'h01, 2'b00);
    vecs[4]  = mk(0,  0, 0, 0, 0, 1, 8'h02, 2'b10, 0, 0, 0,  32, 1, 1, 0, 0, 0, 0, 0, 1, 8'h01, 2'b00);
    vecs[5]  = mk(0,  0, 0, 0, 0, 1, 8'h03, 2'b01, 0, 0, 0,  32, 1, 1, 0, 0, 0, 0, 0, 2, 8'h01, 2'b00);
    vecs[6]  = mk(0,  0, 0, 0, 0, 1, 8'h04, 2'b11, 0, 0, 0,  32, 1, 1, 0, 0, 0, 1, 0, 3, 8'h01, 2'b00);
    vecs[7]  = mk(0,  0, 0, 0, 0, 1, 8'h05, 2'b01, 0, 0, 0,  32, 1, 1, 0, 0, 0, 1, 1, 4, 8'h01, 2'b00);
    vecs[8]  = mk(0,  0, 0, 0, 0, 0, 8'h00, 2'b00, 1, 0, 0,  32, 1, 1, 0, 0, 0, 0, 1, 4, 8'h02, 2'b10);
    vecs[9]  = mk(0,  0, 0, 0, 0, 0, 8'h00, 2'b00, 1, 0, 0,  32, 1, 1, 0, 0, 0, 0, 1, 4, 8'h03, 2'b01);
    vecs[10] = mk(0,  0, 0, 0, 0, 0, 8'h00, 2'b00, 1, 0, 0,  32, 1, 1, 0, 0, 0, 0, 1, 4, 8'h04, 2'b11);
    vecs[11] = mk(0,  0, 0, 0, 0, 0, 8'h00, 2'b00, 1, 0, 0,  32, 1, 1, 0, 0, 1, 0, 1, 4, 8'h00, 2'b00);
    vecs[12] = mk(0,  0, 0, 0, 0, 0, 8'h00, 2'b00, 1, 0, 0,  32, 1, 1, 0, 0, 1, 0, 1, 4, 8'h00, 2'b00);
    vecs[13] = mk(0,  0, 0, 0, 0, 1, 8'hA0, 2'b00, 0, 0, 0,  32, 1, 1, 0, 0, 0, 0, 1, 4, 8'hA0, 2'b00);
    vecs[14] = mk(0,  0, 0, 0, 0, 0, 8'h00, 2'b00, 0, 1, 0,  32, 1, 1, 0, 0, 0, 0, 0, 4, 8'hA0, 2'b00);
    vecs[15] = mk(0,  0, 0, 0, 0, 1, 8'hB1, 2'b00, 0, 0, 0,  32, 1, 1, 0, 0, 0, 0, 0, 4, 8'hA0, 2'b00);
    vecs[16] = mk(0,  0, 0, 0, 0, 1, 8'hB2, 2'b00, 0, 0, 0,  32, 1, 1, 0, 0, 0, 0, 0, 4, 8'hA0, 2'b00);
    vecs[17] = mk(0,  0, 0, 0, 0, 1, 8'hB3, 2'b00, 0, 0, 0,  32, 1, 1, 0, 0, 0, 1, 0, 4, 8'hA0, 2'b00);
    vecs[18] = mk(0,  0, 0, 0, 0, 1, 8'hC4, 2'b00, 1, 0, 0,  32, 1, 1, 0, 0, 0, 1, 0, 4, 8'hB1, 2'b00);
    vecs[19] = mk(0,  0, 0, 0, 0, 0, 8'h00, 2'b00, 1, 0, 0,  32, 1, 1, 0, 0, 0, 0, 0, 4, 8'hB2, 2'b00);
    vecs[20] = mk(0,  0, 0, 0, 0, 0, 8'h00, 2'b00, 1, 0, 0,  32, 1, 1, 0, 0, 0, 0, 0, 4, 8'hB3, 2'b00);
    vecs[21] = mk(0,  0, 0, 0, 0, 0, 8'h00, 2'b00, 1, 0, 0,  32, 1, 1, 0, 0, 0, 0, 0, 4, 8'hC4, 2'b00);
    vecs[22] = mk(0,  0, 0, 0, 0, 0, 8'h00, 2'b00, 1, 0, 0,  32, 1, 1, 0, 0, 1, 0, 0, 4, 8'h00, 2'b00);
    vecs[23] = mk(0,  0, 0, 0, 0, 1, 8'hD0, 2'b00, 0, 0, 0,  32, 1, 1, 0, 0, 0, 0, 0, 4, 8'hD0, 2'b00);
    vecs[24] = mk(0,  0, 0, 0, 0, 1, 8'hD1, 2'b00, 0, 0, 0,  32, 1, 1, 0, 0, 0, 0, 0, 4, 8'hD0, 2'b00);
    vecs[25] = mk(0,  0, 0, 0, 0, 1, 8'hD2, 2'b00, 0, 0, 0,  32, 1, 1, 0, 0, 0, 0, 0, 4, 8'hD0, 2'b00);
    vecs[26] = mk(0,  0, 0, 0, 0, 1, 8'hD3, 2'b00, 0, 0, 0,  32, 1, 1, 0, 0, 0, 1, 0, 4, 8'hD0, 2'b00);
    vecs[27] = mk(0,  0, 0, 0, 0, 1, 8'hD4, 2'b01, 0, 0, 0,  32, 1, 1, 0, 0, 0, 1, 1, 5, 8'hD0, 2'b00);
    vecs[28] = mk(0,  0, 0, 0, 0, 1, 8'hD5, 2'b00, 0, 1, 0,  32, 1, 1, 0, 0, 0, 1, 1, 5, 8'hD0, 2'b00);
    vecs[29] = mk(0,  0, 0, 0, 0, 0, 8'h00, 2'b00, 0, 1, 0,  32, 1, 1, 0, 0, 0, 1, 0, 5, 8'hD0, 2'b00);

    tick();
    tick();
    rst = 1'b0;
    chk_reset_state("reset");

    foreach (vecs[i]) begin
      bus.cfg_wr = vecs[i].cw; bus.cfg_prescale_in = vecs[i].pre;
      bus.cfg_par_en_in = vecs[i].pen; bus.cfg_par_typ_in = vecs[i].pty;
      bus.rx_busy = vecs[i].busy; bus.rx_frame_done = vecs[i].fd; bus.rx_data = vecs[i].data;
      bus.rx_par_err = vecs[i].err[1]; bus.rx_stp_err = vecs[i].err[0];
      bus.rd_en = vecs[i].rd; bus.ovr_clr = vecs[i].oclr; bus.err_clr = vecs[i].eclr;
      tick();
      chk($sformatf("v%0d.Prescale", i), int'(bus.Prescale), int'(vecs[i].e_pre));
      chk($sformatf("v%0d.Par_En", i), int'(bus.Par_En), int'(vecs[i].e_pen));
      chk($sformatf("v%0d.Par_Typ", i), int'(bus.Par_Typ), int'(vecs[i].e_pty));
      chk($sformatf("v%0d.rx_hold", i), int'(bus.rx_hold), int'(vecs[i].e_hold));
      chk($sformatf("v%0d.cfg_pending", i), int'(bus.cfg_pending), int'(vecs[i].e_pend));
      chk($sformatf("v%0d.empty", i), int'(bus.empty), int'(vecs[i].e_empty));
      chk($sformatf("v%0d.full", i), int'(bus.full), int'(vecs[i].e_full));
      chk($sformatf("v%0d.overrun", i), int'(bus.overrun), int'(vecs[i].e_ovr));
      chk($sformatf("v%0d.err_cnt", i), int'(bus.err_cnt), int'(vecs[i].e_ecnt));
      if (!vecs[i].e_empty) begin
        chk($sformatf("v%0d.rd_data", i), int'(bus.rd_data), int'(vecs[i].e_hd));
        chk($sformatf("v%0d.rd_err", i), int'(bus.rd_err), int'(vecs[i].e_he));
      end
    end
    idle_inputs();

    // Mid-frame reconfiguration: two writes while busy, last one wins after busy falls
    bus.rx_busy = 1;
    bus.cfg_wr = 1; bus.cfg_prescale_in = 16;
    tick();
    bus.cfg_wr = 0;
    chk("mid.pending", int'(bus.cfg_pending), 1);
    for (int i = 1; i < 50; i++) begin
      if (i == 10) begin
        bus.cfg_wr = 1; bus.cfg_prescale_in = 8;
      end
      tick();
      bus.cfg_wr = 0;
      chk($sformatf("mid.busy%0d.Prescale", i), int'(bus.Prescale), 32);
      chk($sformatf("mid.busy%0d.rx_hold", i), int'(bus.rx_hold), 1);
    end
    bus.rx_busy = 0;
    tick();
    chk("mid.apply.Prescale", int'(bus.Prescale), 32);
    chk("mid.apply.rx_hold", int'(bus.rx_hold), 1);
    tick();
    chk("mid.run.Prescale", int'(bus.Prescale), 8);
    chk("mid.run.Par_En", int'(bus.Par_En), 0);
    chk("mid.run.Par_Typ", int'(bus.Par_Typ), 0);
    chk("mid.run.cfg_pending", int'(bus.cfg_pending), 0);
    chk("mid.run.rx_hold", int'(bus.rx_hold), 0);

    // Error counter: clear, saturate over 300 stop-bit errors (all dropped on a full FIFO)
    bus.err_clr = 1;
    tick();
    bus.err_clr = 0;
    chk("err.clr", int'(bus.err_cnt), 0);
    bus.rx_frame_done = 1; bus.rx_stp_err = 1; bus.rx_data = 8'hEE;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (i == 254) chk("err.254", int'(bus.err_cnt), 254);
      if (i == 255) chk("err.255", int'(bus.err_cnt), 255);
    end
    chk("err.sat", int'(bus.err_cnt), 255);
    chk("err.full", int'(bus.full), 1);
    chk("err.head", int'(bus.rd_data), 8'hD0);
    bus.err_clr = 1;
    tick();
    chk("err.clr_inc", int'(bus.err_cnt), 1);
    bus.rx_frame_done = 0; bus.rx_stp_err = 0;
    tick();
    chk("err.clr_only", int'(bus.err_cnt), 0);
    bus.err_clr = 0;

    // Reset while waiting for idle with two stored entries
    rst = 1;
    tick();
    rst = 0;
    bus.rx_frame_done = 1; bus.rx_data = 8'h11;
    tick();
    bus.rx_data = 8'h22;
    tick();
    bus.rx_frame_done = 0;
    bus.rx_busy = 1; bus.cfg_wr = 1; bus.cfg_prescale_in = 50;
    bus.cfg_par_en_in = 1; bus.cfg_par_typ_in = 1;
    tick();
    bus.cfg_wr = 0;
    chk("rst.pre.pending", int'(bus.cfg_pending), 1);
    chk("rst.pre.hold", int'(bus.rx_hold), 1);
    chk("rst.pre.head", int'(bus.rd_data), 8'h11);
    rst = 1; bus.rx_frame_done = 1; bus.rd_en = 1; bus.cfg_wr = 1;
    tick();
    chk_reset_state("rst.mid");
    rst = 0; bus.rx_frame_done = 0; bus.rd_en = 0; bus.cfg_wr = 0; bus.rx_busy = 0;
    tick();
    tick();
    tick();
    chk("rst.after.Prescale", int'(bus.Prescale), 8);
    chk("rst.after.Par_En", int'(bus.Par_En), 0);
    chk("rst.after.rx_hold", int'(bus.rx_hold), 0);
    chk("rst.after.empty", int'(bus.empty), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
